aes_key_sched_ctrl: RTL and testbench
=====================================

# aes_key_sched_ctrl

- Sequences the `key_expansion` datapath for AES-128. It accepts a cipher key over a valid/ready handshake and drives `key_expansion`'s `en` and `round` inputs.
- It streams all 11 round keys (index 0..10) to the round datapath over a backpressured valid/ready channel.
- It sits in `aes_core` between the key input interface and the cipher round logic. The `key_expansion` instance lives beside it in the parent.

## Interface
- `NR`, 10, number of rounds; only 10 (AES-128) is supported.
- `clk`  in  1  clock, all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `key_valid`  in  1  cipher key offered.
- `key_ready`  out  1  controller can accept a key.
- `cipher_key`  in  128  key, sampled on the `key_valid && key_ready` handshake.
- `abort`  in  1  cancels the schedule in progress.
- `rk_valid`  out  1  round key presented.
- `rk_ready`  in  1  consumer accepts the round key.
- `rk_data`  out  128  round key.
- `rk_idx`  out  4  round key index, 0..10.
- `rk_last`  out  1  high when `rk_idx == NR`.
- `ke_en`  out  1  to `key_expansion.en`.
- `ke_round`  out  4  to `key_expansion.round`.
- `ke_cipher_key`  out  128  to `key_expansion.cipher_key`.
- `ke_round_key`  in  128  from `key_expansion.round_key`.
- `busy`  out  1  a schedule is in progress.
- `sched_count`  out  16  completed schedules; present only with `KS_PERF_EN`.

## Operation
- State machine `KS_IDLE` / `KS_EMIT`, a 4-bit `idx` counter and a 128-bit `key_hold` register.
- **KS_IDLE**
  - `key_ready = !abort`.
  - On handshake: `key_hold <= cipher_key`, `idx <= 0`, go to `KS_EMIT`.
- **KS_EMIT**
  - `rk_valid = 1`, `rk_idx = idx`.
  - `rk_data = key_hold` when `idx == 0`, else `ke_round_key`.
  - `busy = 1`.
- `ke_cipher_key = key_hold` always.
- `ke_round = idx` always.
- `ke_en = KS_EMIT && rk_valid && rk_ready && idx < NR && !abort`.
  - At the handshake of index k, `key_expansion` computes round key k+1 with Rcon(k).
  - Round key k+1 appears on `ke_round_key` the next cycle.
- Handshake with `idx < NR`: `idx <= idx + 1`, stay in `KS_EMIT`.
- Handshake with `idx == NR` (`rk_last`): return to `KS_IDLE`; `ke_en = 0`.
- `rk_data` and `rk_idx` stay stable while `rk_valid && !rk_ready`. This holds because `key_reg` updates only on a handshake.
- **Abort**
  - `abort` in any state forces `KS_IDLE` next cycle and `idx <= 0`.
  - It suppresses `ke_en` in that cycle.
  - It wins over a same-cycle `rk` or key handshake; that transfer does not count as accepted.
- `key_ready = 0` throughout `KS_EMIT`; a new key is never accepted mid-schedule.

## Timing
- Reset values:
  - `key_ready = 1`
  - `rk_valid = 0`, `rk_idx = 0`, `rk_data = 0`, `rk_last = 0`
  - `ke_en = 0`, `ke_round = 0`, `ke_cipher_key = 0`
  - `busy = 0`, `sched_count = 0`
  - state `KS_IDLE`
- Key handshake in cycle T gives `rk_valid` with index 0 in T+1.
- With `rk_ready` held high, indices 0..10 occupy T+1..T+11 with no bubbles.
- `key_ready` rises in T+12. Minimum key-to-key spacing is 12 cycles.
- Backpressure stalls the stream indefinitely with no state change.
- A reset assertion mid-schedule returns all outputs to their reset values asynchronously.

## Configuration
- `KS_PERF_EN` defined:
  - `sched_count` port exists.
  - It increments on each `rk_last` handshake and wraps 0xFFFF to 0.
  - Abort does not change it; it is cleared only by reset.
- `KS_PERF_EN` undefined: port and counter are absent; all other behaviour is identical.

## Structure
- `aes_pkg` holds:
  - `AES_NR = 10`
  - `AES_KEY_W = 128`
  - `typedef enum {KS_IDLE, KS_EMIT} ks_state_t`
- No sub-module; the FSM and counter are flat.
- `key_expansion` is instantiated in `aes_core`, not inside this block.

## Test plan
- **FIPS-197 key** `2b7e151628aed2a6abf7158809cf4f3c`, `rk_ready = 1`:
  - idx0 = the key.
  - idx1 = `a0fafe1788542cb123a339392a6c7605`.
  - idx10 = `d014f9a8c9ee2589e13f0cc8b6630ca6` with `rk_last`.
  - 11 consecutive cycles; `key_ready` high 12 cycles after the key handshake.
- **Random `rk_ready` (50%)**, same key:
  - identical 11-key sequence.
  - `rk_data`/`rk_idx` stable across stalls.
  - `ke_en` pulses exactly 10 times.
- **Abort at idx 5 with `rk_ready = 1`**:
  - `rk_valid = 0` next cycle; `ke_en` low in the abort cycle.
  - A new key `000102030405060708090a0b0c0d0e0f` then yields idx10 = `13111d7fe3944a17f307a78b4d2b30c5`.
- **`key_valid` and `abort` high together in IDLE**: key not accepted, `busy` stays 0.
- **Reset asserted at idx 7**: all outputs return to reset values immediately; `key_ready = 1` after release.
- **`KS_PERF_EN` defined**:
  - 3 complete schedules plus 1 aborted schedule give `sched_count = 3`.
  - Preload to 0xFFFF via a forced counter, then one schedule, gives 0.

Source files
------------

// File: rtl/aes_key_sched_ctrl_pkg.sv
// Shared AES-128 key-schedule constants and types for the key schedule controller.
// Holds the round count, key width and the controller state encoding.
package aes_key_sched_ctrl_pkg;

    localparam int AES_NR    = 10;
    localparam int AES_KEY_W = 128;

    typedef enum logic {
        KS_IDLE = 1'b0,
        KS_EMIT = 1'b1
    } ks_state_t;

endpackage

// File: rtl/aes_key_sched_ctrl_if.sv
// Key-input and round-key-output channels of the key schedule controller.
// slave: the controller's view; master: the key source / round-key consumer view.
interface aes_key_sched_ctrl_if;
    import aes_key_sched_ctrl_pkg::*;

    logic                 key_valid;
    logic                 key_ready;
    logic [AES_KEY_W-1:0] cipher_key;
    logic                 rk_valid;
    logic                 rk_ready;
    logic [AES_KEY_W-1:0] rk_data;
    logic [3:0]           rk_idx;
    logic                 rk_last;

    modport slave (
        input  key_valid, cipher_key, rk_ready,
        output key_ready, rk_valid, rk_data, rk_idx, rk_last
    );

    modport master (
        output key_valid, cipher_key, rk_ready,
        input  key_ready, rk_valid, rk_data, rk_idx, rk_last
    );

endinterface

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key schedule controller: accepts a cipher key, steps the external
// key_expansion block and streams round keys 0..10 over a valid/ready channel.
// Optional feature macro: KS_PERF_EN adds the completed-schedule counter port sched_count.
module aes_key_sched_ctrl
    import aes_key_sched_ctrl_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input  logic                 clk,
    input  logic                 rst_n,
    aes_key_sched_ctrl_if.slave  bus,
    input  logic                 abort,
    output logic                 ke_en,
    output logic [3:0]           ke_round,
    output logic [AES_KEY_W-1:0] ke_cipher_key,
    input  logic [AES_KEY_W-1:0] ke_round_key,
`ifdef KS_PERF_EN
    output logic [15:0]          sched_count,
`endif
    output logic                 busy
);

    localparam logic [3:0] LP_NR = 4'(NR);

    ks_state_t            r_state;
    logic [3:0]           r_idx;
    logic [AES_KEY_W-1:0] r_key_hold;

    logic w_emit;
    logic w_key_hs;
    logic w_rk_hs;
    logic w_last;

    assign w_emit   = (r_state == KS_EMIT);
    assign w_last   = w_emit && (r_idx == LP_NR);
    // Abort blocks both handshakes in the same cycle, so neither transfer is accepted.
    assign w_key_hs = !w_emit && bus.key_valid && !abort;
    assign w_rk_hs  = w_emit && bus.rk_ready && !abort;

    // Output decode: outputs fall back to zero in idle so they match the reset values.
    assign bus.key_ready = !w_emit && !abort;
    assign bus.rk_valid  = w_emit;
    assign bus.rk_idx    = w_emit ? r_idx : 4'd0;
    assign bus.rk_last   = w_last;
    assign bus.rk_data   = !w_emit ? '0 : ((r_idx == 4'd0) ? r_key_hold : ke_round_key);

    // Round k+1 is requested from key_expansion exactly when round k is taken.
    assign ke_en         = w_rk_hs && (r_idx < LP_NR);
    assign ke_round      = r_idx;
    assign ke_cipher_key = r_key_hold;
    assign busy          = w_emit;

    // Schedule FSM: capture key, advance index on each accepted round key, abort returns to idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= KS_IDLE;
            r_idx      <= 4'd0;
            r_key_hold <= '0;
        end else if (abort) begin
            r_state <= KS_IDLE;
            r_idx   <= 4'd0;
        end else begin
            case (r_state)
                KS_IDLE: begin
                    if (w_key_hs) begin
                        r_key_hold <= bus.cipher_key;
                        r_idx      <= 4'd0;
                        r_state    <= KS_EMIT;
                    end
                end
                KS_EMIT: begin
                    if (w_rk_hs) begin
                        if (w_last) begin
                            r_idx   <= 4'd0;
                            r_state <= KS_IDLE;
                        end else begin
                            r_idx <= r_idx + 4'd1;
                        end
                    end
                end
                default: begin
                    r_state <= KS_IDLE;
                    r_idx   <= 4'd0;
                end
            endcase
        end
    end

`ifdef KS_PERF_EN
    logic [15:0] r_sched_count;

    // Completed-schedule counter: counts accepted final round keys, wraps naturally, reset-only clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sched_count <= 16'd0;
        end else if (w_rk_hs && w_last) begin
            r_sched_count <= r_sched_count + 16'd1;
        end
    end

    assign sched_count = r_sched_count;
`endif

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed testbench for aes_key_sched_ctrl with a behavioural key_expansion model.
// Define KS_PERF_EN to also exercise the completed-schedule counter.
module tb_aes_key_sched_ctrl;
    import aes_key_sched_ctrl_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         abort = 1'b0;
    logic         ke_en;
    logic [3:0]   ke_round;
    logic [127:0] ke_cipher_key;
    logic [127:0] ke_rk = '0;
    logic         busy;
`ifdef KS_PERF_EN
    logic [15:0]  sched_count;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] SEQ_KEY   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] SEQ_RK10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    aes_key_sched_ctrl_if bus ();

    aes_key_sched_ctrl #(.NR(10)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus.slave),
        .abort         (abort),
        .ke_en         (ke_en),
        .ke_round      (ke_round),
        .ke_cipher_key (ke_cipher_key),
        .ke_round_key  (ke_rk),
`ifdef KS_PERF_EN
        .sched_count   (sched_count),
`endif
        .busy          (busy)
    );

    always #5 clk = ~clk;

    logic [7:0] sbox [0:255];

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd0: rcon = 8'h01; 4'd1: rcon = 8'h02; 4'd2: rcon = 8'h04; 4'd3: rcon = 8'h08;
            4'd4: rcon = 8'h10; 4'd5: rcon = 8'h20; 4'd6: rcon = 8'h40; 4'd7: rcon = 8'h80;
            4'd8: rcon = 8'h1b; 4'd9: rcon = 8'h36; default: rcon = 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
        t  = {sbox[w3[23:16]], sbox[w3[15:8]], sbox[w3[7:0]], sbox[w3[31:24]]} ^ {rc, 24'h0};
        w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
        expand = {w0, w1, w2, w3};
    endfunction

    // Behavioural key_expansion: round key k+1 from round key k when enabled.
    always @(posedge clk) begin
        if (ke_en)
            ke_rk <= expand((ke_round == 4'd0) ? ke_cipher_key : ke_rk, rcon(ke_round));
    end

    // Offer a key for one cycle, then run the stream with rk_ready asserted pct% of cycles.
    task automatic do_schedule(input logic [127:0] key, input int pct,
                               output logic [127:0] d0, output logic [127:0] d1,
                               output logic [127:0] d10, output int ken, output int errs,
                               output int cyc, output bit done);
        int exp_idx;
        bit stalled;
        logic [127:0] pd;
        logic [3:0] pi;
        exp_idx = 0; stalled = 0; pd = '0; pi = '0;
        d0 = '0; d1 = '0; d10 = '0; ken = 0; errs = 0; cyc = 0; done = 0;
        @(negedge clk);
        bus.key_valid = 1'b1; bus.cipher_key = key;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            bus.key_valid = 1'b0;
            bus.rk_ready = ($urandom_range(0, 99) < pct);
            #1;
            cyc++;
            if (ke_en) ken++;
            if (!bus.rk_valid) begin
                errs++;
            end else begin
                if (int'(bus.rk_idx) != exp_idx) errs++;
                if (bus.rk_last != (exp_idx == 10)) errs++;
                if (stalled && (bus.rk_data !== pd || bus.rk_idx !== pi)) errs++;
                if (bus.rk_ready) begin
                    if (exp_idx == 0) d0 = bus.rk_data;
                    if (exp_idx == 1) d1 = bus.rk_data;
                    if (exp_idx == 10) begin d10 = bus.rk_data; done = 1; end
                    exp_idx++;
                    stalled = 0;
                end else begin
                    stalled = 1; pd = bus.rk_data; pi = bus.rk_idx;
                end
            end
        end
        bus.rk_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.key_ready !== 1'b1) $display("FAIL reset.key_ready got %b want 1", bus.key_ready); else n_pass++;
        n_checks++; if (bus.rk_valid !== 1'b0) $display("FAIL reset.rk_valid got %b want 0", bus.rk_valid); else n_pass++;
        n_checks++; if (bus.rk_idx !== 4'd0) $display("FAIL reset.rk_idx got %0d want 0", bus.rk_idx); else n_pass++;
        n_checks++; if (bus.rk_data !== 128'd0) $display("FAIL reset.rk_data got %h want 0", bus.rk_data); else n_pass++;
        n_checks++; if (bus.rk_last !== 1'b0) $display("FAIL reset.rk_last got %b want 0", bus.rk_last); else n_pass++;
        n_checks++; if (ke_en !== 1'b0) $display("FAIL reset.ke_en got %b want 0", ke_en); else n_pass++;
        n_checks++; if (ke_round !== 4'd0) $display("FAIL reset.ke_round got %0d want 0", ke_round); else n_pass++;
        n_checks++; if (ke_cipher_key !== 128'd0) $display("FAIL reset.ke_cipher_key got %h want 0", ke_cipher_key); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset.busy got %b want 0", busy); else n_pass++;
`ifdef KS_PERF_EN
        n_checks++; if (sched_count !== 16'd0) $display("FAIL reset.sched_count got %0d want 0", sched_count); else n_pass++;
`endif
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_fips();
        logic [127:0] d0, d1, d10; int ken, errs, cyc; bit done;
        do_schedule(FIPS_KEY, 100, d0, d1, d10, ken, errs, cyc, done);
        n_checks++; if (!done) $display("FAIL fips.done timed out after %0d cycles", cyc); else n_pass++;
        n_checks++; if (d0 !== FIPS_KEY) $display("FAIL fips.idx0 got %h want %h", d0, FIPS_KEY); else n_pass++;
        n_checks++; if (d1 !== FIPS_RK1) $display("FAIL fips.idx1 got %h want %h", d1, FIPS_RK1); else n_pass++;
        n_checks++; if (d10 !== FIPS_RK10) $display("FAIL fips.idx10 got %h want %h", d10, FIPS_RK10); else n_pass++;
        n_checks++; if (cyc != 11) $display("FAIL fips.cycles got %0d want 11", cyc); else n_pass++;
        n_checks++; if (errs != 0) $display("FAIL fips.sequence got %0d errors want 0", errs); else n_pass++;
        n_checks++; if (ken != 10) $display("FAIL fips.ke_en_pulses got %0d want 10", ken); else n_pass++;
        n_checks++; if (bus.key_ready !== 1'b0) $display("FAIL fips.key_ready_T11 got %b want 0", bus.key_ready); else n_pass++;
        @(negedge clk); #1;
        n_checks++; if (bus.key_ready !== 1'b1) $display("FAIL fips.key_ready_T12 got %b want 1", bus.key_ready); else n_pass++;
        n_checks++; if (busy !== 1'b0 || bus.rk_valid !== 1'b0) $display("FAIL fips.idle_T12 got busy=%b rk_valid=%b want 0/0", busy, bus.rk_valid); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [127:0] d0, d1, d10; int ken, errs, cyc; bit done;
        do_schedule(FIPS_KEY, 50, d0, d1, d10, ken, errs, cyc, done);
        n_checks++; if (!done) $display("FAIL bp.done timed out after %0d cycles", cyc); else n_pass++;
        n_checks++; if (d0 !== FIPS_KEY) $display("FAIL bp.idx0 got %h want %h", d0, FIPS_KEY); else n_pass++;
        n_checks++; if (d1 !== FIPS_RK1) $display("FAIL bp.idx1 got %h want %h", d1, FIPS_RK1); else n_pass++;
        n_checks++; if (d10 !== FIPS_RK10) $display("FAIL bp.idx10 got %h want %h", d10, FIPS_RK10); else n_pass++;
        n_checks++; if (errs != 0) $display("FAIL bp.stable_sequence got %0d errors want 0", errs); else n_pass++;
        n_checks++; if (ken != 10) $display("FAIL bp.ke_en_pulses got %0d want 10", ken); else n_pass++;
    endtask

    task automatic test_abort();
        logic [127:0] d0, d1, d10; int ken, errs, cyc; bit done, hit;
        hit = 0;
        @(negedge clk);
        bus.key_valid = 1'b1; bus.cipher_key = FIPS_KEY; bus.rk_ready = 1'b1;
        for (int c = 0; c < 20 && !hit; c++) begin
            @(negedge clk);
            bus.key_valid = 1'b0;
            #1;
            if (bus.rk_valid && bus.rk_idx == 4'd5) begin
                abort = 1'b1; #1; hit = 1;
                n_checks++; if (ke_en !== 1'b0) $display("FAIL abort.ke_en got %b want 0", ke_en); else n_pass++;
            end
        end
        n_checks++; if (!hit) $display("FAIL abort.reach_idx5 got timeout want idx5"); else n_pass++;
        @(negedge clk); abort = 1'b0; #1;
        n_checks++; if (bus.rk_valid !== 1'b0) $display("FAIL abort.rk_valid got %b want 0", bus.rk_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL abort.busy got %b want 0", busy); else n_pass++;
        do_schedule(SEQ_KEY, 100, d0, d1, d10, ken, errs, cyc, done);
        n_checks++; if (d0 !== SEQ_KEY) $display("FAIL abort.new_idx0 got %h want %h", d0, SEQ_KEY); else n_pass++;
        n_checks++; if (d10 !== SEQ_RK10) $display("FAIL abort.new_idx10 got %h want %h", d10, SEQ_RK10); else n_pass++;
        n_checks++; if (errs != 0 || !done) $display("FAIL abort.new_sequence got %0d errors done=%b want 0/1", errs, done); else n_pass++;
    endtask

    task automatic test_key_abort_same();
        @(negedge clk);
        bus.key_valid = 1'b1; bus.cipher_key = SEQ_KEY; abort = 1'b1;
        #1;
        n_checks++; if (bus.key_ready !== 1'b0) $display("FAIL keyabort.key_ready got %b want 0", bus.key_ready); else n_pass++;
        @(negedge clk);
        bus.key_valid = 1'b0; abort = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL keyabort.busy got %b want 0", busy); else n_pass++;
        n_checks++; if (bus.rk_valid !== 1'b0) $display("FAIL keyabort.rk_valid got %b want 0", bus.rk_valid); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit hit;
        hit = 0;
        @(negedge clk);
        bus.key_valid = 1'b1; bus.cipher_key = FIPS_KEY; bus.rk_ready = 1'b1;
        for (int c = 0; c < 20 && !hit; c++) begin
            @(negedge clk);
            bus.key_valid = 1'b0;
            #1;
            if (bus.rk_valid && bus.rk_idx == 4'd7) hit = 1;
        end
        n_checks++; if (!hit) $display("FAIL rstmid.reach_idx7 got timeout want idx7"); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.rk_valid !== 1'b0 || bus.rk_idx !== 4'd0 || bus.rk_data !== 128'd0 || bus.rk_last !== 1'b0)
            $display("FAIL rstmid.rk_outputs got v=%b i=%0d d=%h l=%b want 0", bus.rk_valid, bus.rk_idx, bus.rk_data, bus.rk_last); else n_pass++;
        n_checks++; if (ke_en !== 1'b0 || ke_round !== 4'd0 || ke_cipher_key !== 128'd0 || busy !== 1'b0)
            $display("FAIL rstmid.ke_outputs got en=%b r=%0d k=%h busy=%b want 0", ke_en, ke_round, ke_cipher_key, busy); else n_pass++;
        @(negedge clk); rst_n = 1'b1; #1;
        n_checks++; if (bus.key_ready !== 1'b1) $display("FAIL rstmid.key_ready got %b want 1", bus.key_ready); else n_pass++;
    endtask

`ifdef KS_PERF_EN
    task automatic test_perf();
        logic [127:0] d0, d1, d10; int ken, errs, cyc; bit done;
        n_checks++; if (sched_count !== 16'd0) $display("FAIL perf.start got %0d want 0", sched_count); else n_pass++;
        for (int s = 0; s < 3; s++) do_schedule(FIPS_KEY, 100, d0, d1, d10, ken, errs, cyc, done);
        @(negedge clk);
        bus.key_valid = 1'b1; bus.cipher_key = SEQ_KEY;
        @(negedge clk); bus.key_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0; #1;
        n_checks++; if (sched_count !== 16'd3) $display("FAIL perf.count3 got %0d want 3", sched_count); else n_pass++;
        force dut.r_sched_count = 16'hFFFF;
        #1;
        release dut.r_sched_count;
        do_schedule(FIPS_KEY, 100, d0, d1, d10, ken, errs, cyc, done);
        @(negedge clk); #1;
        n_checks++; if (sched_count !== 16'd0) $display("FAIL perf.wrap got %0d want 0", sched_count); else n_pass++;
    endtask
`endif

    initial begin
        sbox = '{
            8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
            8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
            8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
            8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
            8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
            8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
            8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
            8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
            8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
            8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
            8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
            8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
            8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
            8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
            8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
            8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16};
        bus.key_valid = 1'b0;
        bus.cipher_key = '0;
        bus.rk_ready = 1'b1;
        test_reset();
        test_fips();
        test_backpressure();
        test_abort();
        test_key_abort_same();
        test_reset_mid();
`ifdef KS_PERF_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
